// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-2 demultiplexer: select
// encodings and the per-slot EMPTY/FULL state type.
package demux_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One output holding slot: a single data register plus an EMPTY/FULL flag.
// The slot can accept new data when it is empty or is being drained in the
// same cycle, which gives full throughput without a bubble.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_i,
    input  logic [WIDTH-1:0] fill_data_i,
    input  logic             ready_in_i,
    output logic             valid_out_o,
    output logic [WIDTH-1:0] data_out_o,
    output logic             can_accept_o
);

    slot_state_e      state_q;
    logic [WIDTH-1:0] data_q;

    // Slot FSM: load on fill, empty on a drain that is not refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (fill_i) begin
                        state_q <= SLOT_FULL;
                        data_q  <= fill_data_i;
                    end
                end
                SLOT_FULL: begin
                    if (fill_i) begin
                        data_q <= fill_data_i;
                    end else if (ready_in_i) begin
                        state_q <= SLOT_EMPTY;
                    end
                end
                default: begin
                    state_q <= SLOT_EMPTY;
                end
            endcase
        end
    end

    assign valid_out_o  = (state_q == SLOT_FULL);
    assign data_out_o   = data_q;
    // A full slot whose consumer is taking data this cycle frees its place.
    assign can_accept_o = (state_q == SLOT_EMPTY) || ready_in_i;

endmodule

// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 demultiplexer. Steers the producer stream to slot A
// (in_sel=0) or slot B (in_sel=1), each holding one beat with a
// valid/ready handshake. Optional per-destination transfer counters are
// built only when DEMUX_STATS_EN is defined; otherwise cnt_a/cnt_b read 0.
module demux_1x2_reg
    import demux_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sel,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [WIDTH-1:0]     a_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [WIDTH-1:0]     b_data,
    output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0] cnt_b
);

    logic a_can_accept;
    logic b_can_accept;
    logic fill_a;
    logic fill_b;

    // Only the selected destination decides whether the producer may proceed.
    assign in_ready = (in_sel == SEL_A) ? a_can_accept : b_can_accept;
    assign fill_a   = in_valid && in_ready && (in_sel == SEL_A);
    assign fill_b   = in_valid && in_ready && (in_sel == SEL_B);

    demux_out_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .fill_i       (fill_a),
        .fill_data_i  (in_data),
        .ready_in_i   (a_ready),
        .valid_out_o  (a_valid),
        .data_out_o   (a_data),
        .can_accept_o (a_can_accept)
    );

    demux_out_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .fill_i       (fill_b),
        .fill_data_i  (in_data),
        .ready_in_i   (b_ready),
        .valid_out_o  (b_valid),
        .data_out_o   (b_data),
        .can_accept_o (b_can_accept)
    );

`ifdef DEMUX_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_a_q;
    logic [CNT_WIDTH-1:0] cnt_b_q;

    // Count accepted beats per destination; wraps naturally at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            if (fill_a) begin
                cnt_a_q <= cnt_a_q + 1'b1;
            end
            if (fill_b) begin
                cnt_b_q <= cnt_b_q + 1'b1;
            end
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`else
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

endmodule
